// File: rtl/led_pwm_avalon.sv
// Avalon-MM LED controller: per-LED 8-bit PWM with frame-synchronous duty
// updates, optional global blink and per-LED direct override.
module led_pwm_avalon #(
  parameter int          PRESCALE = 195,
  parameter int          BLINK_W  = 24,
  parameter logic [31:0] ID_VALUE = 32'h4C45_4401
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic [3:0]  led_out
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]   pre;
  logic [7:0]         pwm_cnt;
  logic               tick;
  logic               frame_end;

  logic               enable;
  logic               blink_en;
  logic [3:0]         direct_mask;
  logic [3:0]         direct_val;
  logic [31:0]        duty_shadow;
  logic [31:0]        duty_shadow_nxt;
  logic [31:0]        duty_act;
  logic [BLINK_W-1:0] blink_reload;
  logic [BLINK_W-1:0] bcnt;
  logic               blink_phase;
  logic               pending;

  logic [31:0]        be_mask;
  logic [BLINK_W-1:0] blink_mask;
  logic               wr_ctrl;
  logic               wr_duty;
  logic               wr_blink;
  logic               duty_load;
  logic [3:0]         pwm_on;
  logic [3:0]         led_nxt;
  logic [31:0]        rd_mux;

  always_comb begin
    be_mask    = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                  {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
    blink_mask = be_mask[BLINK_W-1:0];
    wr_ctrl    = avs_write && (avs_address == 3'd0);
    wr_duty    = avs_write && (avs_address == 3'd1);
    wr_blink   = avs_write && (avs_address == 3'd2);
    tick       = (pre == PRE_MAX);
    frame_end  = tick && (pwm_cnt == 8'hFF);
    // Shadow is merged first so a write landing on frame_end is loaded at once
    duty_shadow_nxt = wr_duty ? ((duty_shadow & ~be_mask) | (avs_writedata & be_mask))
                              : duty_shadow;
    duty_load  = frame_end || !enable;
  end

  always_comb begin
    pwm_on  = '0;
    led_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      pwm_on[i]  = pwm_cnt < duty_act[8*i +: 8];
      led_nxt[i] = direct_mask[i] ? direct_val[i] : (enable & blink_phase & pwm_on[i]);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd0:    rd_mux = {20'd0, direct_val, direct_mask, 2'b00, blink_en, enable};
      3'd1:    rd_mux = duty_shadow;
      3'd2:    rd_mux = 32'(blink_reload);
      3'd3:    rd_mux = {15'd0, pending, pwm_cnt, 7'd0, blink_phase};
      3'd4:    rd_mux = ID_VALUE;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre               <= '0;
      pwm_cnt           <= '0;
      enable            <= 1'b0;
      blink_en          <= 1'b0;
      direct_mask       <= '0;
      direct_val        <= '0;
      duty_shadow       <= '0;
      duty_act          <= '0;
      blink_reload      <= '0;
      bcnt              <= '0;
      blink_phase       <= 1'b1;
      pending           <= 1'b0;
      led_out           <= '0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick)
        pwm_cnt <= pwm_cnt + 8'd1;

      if (wr_ctrl && avs_byteenable[0]) begin
        enable      <= avs_writedata[0];
        blink_en    <= avs_writedata[1];
        direct_mask <= avs_writedata[7:4];
      end
      if (wr_ctrl && avs_byteenable[1])
        direct_val <= avs_writedata[11:8];
      if (wr_blink)
        blink_reload <= (blink_reload & ~blink_mask) | (avs_writedata[BLINK_W-1:0] & blink_mask);

      duty_shadow <= duty_shadow_nxt;
      if (duty_load) begin
        duty_act <= duty_shadow_nxt;
        pending  <= 1'b0;
      end else if (wr_duty) begin
        pending  <= 1'b1;
      end

      if (!blink_en) begin
        blink_phase <= 1'b1;
        bcnt        <= '0;
      end else if (frame_end) begin
        if (bcnt == blink_reload) begin
          blink_phase <= ~blink_phase;
          bcnt        <= '0;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end

      led_out           <= led_nxt;
      avs_readdatavalid <= avs_read;
      if (avs_read)
        avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_led_pwm_avalon.sv
// Bench for led_pwm_avalon: directed read table, PWM/blink/override sequences
// and a randomized bus phase checked every cycle against a frame-arithmetic model.
module tb_led_pwm_avalon;

  localparam int          PRESC = 1;
  localparam int          FRAME = 256 * PRESC;
  localparam logic [31:0] ID    = 32'h4C45_4401;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [3:0]  led_out;

  int checks = 0;
  int errors = 0;

  led_pwm_avalon #(.PRESCALE(PRESC), .BLINK_W(24), .ID_VALUE(ID)) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .led_out(led_out)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset determines the PWM position directly
  int        m_t;
  bit        m_en, m_ben, m_phase, m_pending, m_rdv;
  bit [3:0]  m_dmask, m_dval, m_led;
  bit [7:0]  m_sh[4];
  bit [7:0]  m_act[4];
  bit [23:0] m_reload;
  int        m_bcnt;
  bit [31:0] m_rdata;

  function automatic bit [31:0] m_read(input bit [2:0] a, input int pc);
    case (a)
      3'd0:    return {20'd0, m_dval, m_dmask, 2'b00, m_ben, m_en};
      3'd1:    return {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
      3'd2:    return {8'd0, m_reload};
      3'd3:    return {15'd0, m_pending, 8'(pc), 7'd0, m_phase};
      3'd4:    return ID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    int pc;
    bit fe, old_en, duty_wr;
    bit [3:0] nled;
    if (reset) begin
      m_t = 0; m_en = 0; m_ben = 0; m_dmask = 0; m_dval = 0; m_reload = 0;
      m_bcnt = 0; m_phase = 1; m_pending = 0; m_led = 0; m_rdv = 0; m_rdata = 0;
      for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_act[i] = 0; end
      return;
    end
    pc = (m_t / PRESC) % 256;
    fe = (m_t % FRAME) == FRAME - 1;
    for (int i = 0; i < 4; i++)
      nled[i] = m_dmask[i] ? m_dval[i] : (m_en && m_phase && (pc < int'(m_act[i])));
    m_rdv = avs_read;
    if (avs_read) m_rdata = m_read(avs_address, pc);
    if (!m_ben) begin
      m_phase = 1; m_bcnt = 0;
    end else if (fe) begin
      if (m_bcnt == int'(m_reload)) begin m_phase = !m_phase; m_bcnt = 0; end
      else m_bcnt++;
    end
    old_en  = m_en;
    duty_wr = avs_write && avs_address == 3'd1;
    if (avs_write) begin
      for (int b = 0; b < 4; b++) begin
        if (avs_byteenable[b]) begin
          case (avs_address)
            3'd0: begin
              if (b == 0) begin
                m_en = avs_writedata[0]; m_ben = avs_writedata[1]; m_dmask = avs_writedata[7:4];
              end
              if (b == 1) m_dval = avs_writedata[11:8];
            end
            3'd1: m_sh[b] = avs_writedata[8*b +: 8];
            3'd2: if (b < 3) m_reload[8*b +: 8] = avs_writedata[8*b +: 8];
            default: ;
          endcase
        end
      end
    end
    if (duty_wr) m_pending = 1;
    if (fe || !old_en) begin
      for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
      m_pending = 0;
    end
    m_led = nled;
    m_t++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("led_out", 32'(led_out), 32'(m_led));
    chk("readdatavalid", 32'(avs_readdatavalid), 32'(m_rdv));
    if (m_rdv) chk("readdata", avs_readdata, m_rdata);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    step();
    avs_write = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    step();
    d = avs_readdata;
    avs_read = 1'b0;
  endtask

  task automatic count_led(input int n, output int c0, output int chi, output int cf, output int cz);
    c0 = 0; chi = 0; cf = 0; cz = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (led_out[0]) c0++;
      if (led_out[3:1] != 3'b000) chi++;
      if (led_out == 4'hF) cf++;
      if (led_out == 4'h0) cz++;
    end
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] exp;
  } rvec_t;

  rvec_t tab[8];

  initial begin
    logic [31:0] d;
    int c0, chi, cf, cz;
    bit done;

    tab[0] = '{3'd3, 32'h0000_0001};
    tab[1] = '{3'd0, 32'h0};
    tab[2] = '{3'd1, 32'h0};
    tab[3] = '{3'd2, 32'h0};
    tab[4] = '{3'd4, ID};
    tab[5] = '{3'd5, 32'h0};
    tab[6] = '{3'd6, 32'h0};
    tab[7] = '{3'd7, 32'h0};

    repeat (3) step();
    reset = 1'b0;

    // Back-to-back reads straight out of reset
    for (int k = 0; k < 8; k++) begin
      avs_address = tab[k].addr; avs_read = 1'b1;
      step();
      chk("tab_rdvalid", 32'(avs_readdatavalid), 32'd1);
      chk("tab_rdata", avs_readdata, tab[k].exp);
    end
    avs_read = 1'b0;
    step();
    chk("rdvalid_drop", 32'(avs_readdatavalid), 32'd0);

    // Half duty on LED0
    wr_reg(3'd1, 32'h0000_0080);
    wr_reg(3'd0, 32'h0000_0001);
    repeat (4) step();
    count_led(FRAME, c0, chi, cf, cz);
    chk("duty80_high", 32'(c0), 32'd128);
    chk("duty80_others", 32'(chi), 32'd0);

    // Duty change waits for the frame boundary
    wr_reg(3'd1, 32'h0000_0040);
    rd_reg(3'd3, d);
    chk("pending_set", 32'(d[16]), 32'd1);
    done = 0;
    for (int k = 0; k < 2 * FRAME && !done; k++) begin
      rd_reg(3'd3, d);
      if (d[16] == 1'b0) done = 1;
    end
    chk("pending_clear_timeout", 32'(done), 32'd1);
    count_led(FRAME, c0, chi, cf, cz);
    chk("duty40_high", 32'(c0), 32'd64);

    // Direct override
    wr_reg(3'd0, 32'h0000_05F0);
    step();
    chk("direct_2cyc", 32'(led_out), 32'h5);
    repeat (20) step();
    chk("direct_hold", 32'(led_out), 32'h5);

    // Blink every 3 frames at 255/256 duty
    wr_reg(3'd0, 32'h0000_0003);
    wr_reg(3'd1, 32'hFFFF_FFFF);
    wr_reg(3'd2, 32'h0000_0002);
    repeat (2 * FRAME) step();
    count_led(6 * FRAME, c0, chi, cf, cz);
    chk("blink_lit", 32'(cf), 32'd765);
    chk("blink_dark", 32'(cz), 32'd771);

    // Byte-lane write and unmapped address
    wr_reg(3'd0, 32'h0000_0F01, 4'b0010);
    rd_reg(3'd0, d);
    chk("be_ctrl", d, 32'h0000_0F03);
    wr_reg(3'd6, 32'hFFFF_FFFF);
    rd_reg(3'd6, d);
    chk("addr6", d, 32'h0);
    rd_reg(3'd0, d);
    chk("ctrl_after_addr6", d, 32'h0000_0F03);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      avs_read       = ($urandom_range(0, 99) < 30);
      avs_write      = ($urandom_range(0, 99) < 20);
      avs_address    = 3'($urandom_range(0, 7));
      avs_byteenable = 4'($urandom_range(0, 15));
      avs_writedata  = $urandom;
      if (avs_address == 3'd2) avs_writedata = 32'($urandom_range(0, 3));
      reset          = ($urandom_range(0, 999) == 0);
      step();
    end
    avs_read = 1'b0; avs_write = 1'b0; reset = 1'b0;
    step();

    // Reset while lit
    wr_reg(3'd0, 32'h0000_0001);
    wr_reg(3'd1, 32'hFFFF_FFFF);
    repeat (100) step();
    reset = 1'b1;
    step();
    chk("reset_led", 32'(led_out), 32'h0);
    reset = 1'b0;
    rd_reg(3'd3, d);
    chk("reset_status", d, 32'h0000_0001);
    rd_reg(3'd0, d);
    chk("reset_ctrl", d, 32'h0);
    rd_reg(3'd1, d);
    chk("reset_duty", d, 32'h0);
    rd_reg(3'd2, d);
    chk("reset_blink", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
